// File: rtl/switch_key_input.sv
// switch_key_input: debounced slide-switch / push-key input peripheral.
// Ports: clk, reset_n, sw, key_n in; addr/in/load CPU write side; out read data.
//
//   clk      system clock, all state on posedge
//   reset_n  asynchronous active-low reset
//   sw       raw slide switches (asynchronous, 1 = on)
//   key_n    raw push keys (asynchronous, 0 = pressed)
//   addr     0 = SWITCH word, 1 = KEY word
//   in       CPU write data; in[4+i] = 1 clears key event i
//   load     CPU write strobe
//   out      read data, combinational from addr and registered state

// Per-bit two-flop synchroniser followed by an independent debounce counter.
// SYNC_RST is the idle level loaded into the synchroniser on reset, so a
// reset never looks like an input edge. INVERT flips polarity after the
// synchroniser so active-low inputs come out as 1 = asserted.
// rise flags bits whose debounced level goes 0 -> 1 on the coming edge.
module switch_key_input_db #(
    parameter int W               = 1,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit SYNC_RST        = 1'b0,
    parameter bit INVERT          = 1'b0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] raw,
    output logic [W-1:0] stable,
    output logic [W-1:0] rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [W-1:0]  s1_q;
    logic [W-1:0]  s1_d;
    logic [W-1:0]  s2_q;
    logic [W-1:0]  s2_d;
    logic [W-1:0]  stable_q;
    logic [W-1:0]  stable_d;
    logic [W-1:0]  synced;
    logic [CW-1:0] cnt_q [W];
    logic [CW-1:0] cnt_d [W];

    always_comb begin
        s1_d     = raw;
        s2_d     = s1_q;
        synced   = INVERT ? ~s2_q : s2_q;
        stable_d = stable_q;
        for (int i = 0; i < W; i++) begin
            cnt_d[i] = '0;
            // Any return to the stable level restarts the count, so a glitch
            // shorter than the full window can never be accepted.
            if (synced[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = synced[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        rise = stable_d & ~stable_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q     <= {W{SYNC_RST}};
            s2_q     <= {W{SYNC_RST}};
            stable_q <= '0;
            for (int i = 0; i < W; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            for (int i = 0; i < W; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign stable = stable_q;

endmodule

module switch_key_input #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SW_W            = 10,
    parameter int KEY_W           = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [SW_W-1:0]  sw,
    input  logic [KEY_W-1:0] key_n,
    input  logic             addr,
    input  logic [15:0]      in,
    input  logic             load,
    output logic [15:0]      out
);

    // The key word packs events at bit 4 and levels at bit 0, so the two
    // fields only stay disjoint for up to four keys.
    if (KEY_W < 1 || KEY_W > 4) begin : g_bad_key_w
        $error("switch_key_input: KEY_W must be 1..4");
    end
    if (SW_W < 1 || SW_W > 16) begin : g_bad_sw_w
        $error("switch_key_input: SW_W must be 1..16");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_db
        $error("switch_key_input: DEBOUNCE_CYCLES must be >= 2");
    end

    logic [SW_W-1:0]  sw_stable;
    logic [SW_W-1:0]  sw_rise_unused;
    logic [KEY_W-1:0] key_stable;
    logic [KEY_W-1:0] key_rise;
    logic [KEY_W-1:0] key_evt_q;
    logic [KEY_W-1:0] key_evt_d;
    logic [KEY_W-1:0] key_clr;
    logic [15:0]      key_word;
    logic             unused_in;

    switch_key_input_db #(
        .W               (SW_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_RST        (1'b0),
        .INVERT          (1'b0)
    ) u_sw_db (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (sw),
        .stable  (sw_stable),
        .rise    (sw_rise_unused)
    );

    // Keys idle high, so the synchroniser resets to 1 (released).
    switch_key_input_db #(
        .W               (KEY_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_RST        (1'b1),
        .INVERT          (1'b1)
    ) u_key_db (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (key_n),
        .stable  (key_stable),
        .rise    (key_rise)
    );

    always_comb begin
        key_clr = '0;
        if (load && addr) begin
            key_clr = in[4 +: KEY_W];
        end
        // Set is ORed in after the clear so a press accepted on the same
        // edge as its clear is never lost.
        key_evt_d = (key_evt_q & ~key_clr) | key_rise;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_evt_q <= '0;
        end else begin
            key_evt_q <= key_evt_d;
        end
    end

    always_comb begin
        key_word = '0;
        for (int i = 0; i < KEY_W; i++) begin
            key_word[i]     = key_stable[i];
            key_word[4 + i] = key_evt_q[i];
        end
        out = addr ? key_word : 16'(sw_stable);
    end

    assign unused_in = ^{in, sw_rise_unused};

endmodule

// File: tb/tb_switch_key_input.sv
// tb_switch_key_input: directed checks of switch_key_input with DEBOUNCE_CYCLES=4.
// Ports: none; drives the DUT and prints one summary line.
module tb_switch_key_input;

    logic        clk;
    logic        reset_n;
    logic [9:0]  sw;
    logic [3:0]  key_n;
    logic        addr;
    logic [15:0] din;
    logic        load;
    logic [15:0] dout;

    int total;
    int bad;

    switch_key_input #(
        .DEBOUNCE_CYCLES (4),
        .SW_W            (10),
        .KEY_W           (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sw      (sw),
        .key_n   (key_n),
        .addr    (addr),
        .in      (din),
        .load    (load),
        .out     (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        sw      = '0;
        key_n   = 4'hF;
        load    = 1'b0;
        addr    = 1'b0;
        din     = '0;
        tick();
        tick();
        reset_n = 1'b1;
        repeat (8) tick();
    endtask

    task automatic cpu_write(input logic a, input logic [15:0] d);
        addr = a;
        din  = d;
        load = 1'b1;
        tick();
        load = 1'b0;
        din  = '0;
        addr = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        logic [15:0] exp;
        reset_n = 1'b0;
        sw      = 10'h3FF;
        key_n   = 4'h0;
        load    = 1'b0;
        din     = '0;
        addr    = 1'b0;
        repeat (3) tick();
        total++;
        if (dout !== 16'h0000) begin
            bad++;
            $display("FAIL reset_addr0 got=%h exp=0000", dout);
        end
        addr = 1'b1;
        #1;
        total++;
        if (dout !== 16'h0000) begin
            bad++;
            $display("FAIL reset_addr1 got=%h exp=0000", dout);
        end
        addr    = 1'b0;
        reset_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            exp = (e == 6) ? 16'h03FF : 16'h0000;
            total++;
            if (dout !== exp) begin
                bad++;
                $display("FAIL reset_sw_edge%0d got=%h exp=%h", e, dout, exp);
            end
        end
        addr = 1'b1;
        #1;
        total++;
        if (dout !== 16'h00FF) begin
            bad++;
            $display("FAIL reset_key_held got=%h exp=00FF", dout);
        end
    endtask

    task automatic test_bounce;
        logic [15:0] exp;
        do_reset();
        addr = 1'b0;
        for (int p = 0; p < 4; p++) begin
            sw[0] = (p % 2 == 0);
            repeat (2) begin
                tick();
                total++;
                if (dout[0] !== 1'b0) begin
                    bad++;
                    $display("FAIL bounce_p%0d got=%b exp=0", p, dout[0]);
                end
            end
        end
        sw[0] = 1'b0;
        repeat (10) begin
            tick();
            total++;
            if (dout !== 16'h0000) begin
                bad++;
                $display("FAIL bounce_hold got=%h exp=0000", dout);
            end
        end
        sw = 10'h201;
        for (int e = 1; e <= 6; e++) begin
            tick();
            exp = (e == 6) ? 16'h0201 : 16'h0000;
            total++;
            if (dout !== exp) begin
                bad++;
                $display("FAIL sw_accept_edge%0d got=%h exp=%h", e, dout, exp);
            end
        end
    endtask

    task automatic test_key_press;
        logic [15:0] exp;
        do_reset();
        addr  = 1'b1;
        key_n = 4'b1011;
        for (int e = 1; e <= 10; e++) begin
            tick();
            exp = (e >= 6) ? 16'h0044 : 16'h0000;
            total++;
            if (dout !== exp) begin
                bad++;
                $display("FAIL press_edge%0d got=%h exp=%h", e, dout, exp);
            end
        end
        key_n = 4'hF;
        for (int e = 1; e <= 6; e++) begin
            tick();
            exp = (e == 6) ? 16'h0040 : 16'h0044;
            total++;
            if (dout !== exp) begin
                bad++;
                $display("FAIL release_edge%0d got=%h exp=%h", e, dout, exp);
            end
        end
    endtask

    task automatic test_w1c;
        do_reset();
        addr  = 1'b1;
        key_n = 4'b1010;
        repeat (8) tick();
        key_n = 4'hF;
        repeat (8) tick();
        total++;
        if (dout !== 16'h0050) begin
            bad++;
            $display("FAIL w1c_pending got=%h exp=0050", dout);
        end
        cpu_write(1'b1, 16'h0010);
        total++;
        if (dout !== 16'h0040) begin
            bad++;
            $display("FAIL w1c_clear0 got=%h exp=0040", dout);
        end
        cpu_write(1'b1, 16'h0000);
        total++;
        if (dout !== 16'h0040) begin
            bad++;
            $display("FAIL w1c_zero got=%h exp=0040", dout);
        end
        cpu_write(1'b0, 16'hFFFF);
        total++;
        if (dout !== 16'h0040) begin
            bad++;
            $display("FAIL w1c_addr0 got=%h exp=0040", dout);
        end
        addr = 1'b0;
        #1;
        total++;
        if (dout !== 16'h0000) begin
            bad++;
            $display("FAIL w1c_addr0_read got=%h exp=0000", dout);
        end
        cpu_write(1'b1, 16'h00F0);
        total++;
        if (dout !== 16'h0000) begin
            bad++;
            $display("FAIL w1c_all got=%h exp=0000", dout);
        end
    endtask

    task automatic test_collision;
        do_reset();
        addr  = 1'b1;
        key_n = 4'b1101;
        repeat (5) tick();
        total++;
        if (dout !== 16'h0000) begin
            bad++;
            $display("FAIL coll_pre got=%h exp=0000", dout);
        end
        // Clear lands on edge 6, the edge the press is accepted.
        din  = 16'h0020;
        load = 1'b1;
        tick();
        load = 1'b0;
        din  = '0;
        total++;
        if (dout !== 16'h0022) begin
            bad++;
            $display("FAIL coll_set_wins got=%h exp=0022", dout);
        end
        cpu_write(1'b1, 16'h0020);
        total++;
        if (dout !== 16'h0002) begin
            bad++;
            $display("FAIL held_clear got=%h exp=0002", dout);
        end
        repeat (8) tick();
        total++;
        if (dout !== 16'h0002) begin
            bad++;
            $display("FAIL held_no_evt got=%h exp=0002", dout);
        end
        key_n = 4'hF;
        repeat (8) tick();
        key_n = 4'b1101;
        repeat (8) tick();
        total++;
        if (dout !== 16'h0022) begin
            bad++;
            $display("FAIL repress_evt got=%h exp=0022", dout);
        end
    endtask

    task automatic test_mid_reset;
        logic [15:0] exp;
        do_reset();
        addr  = 1'b1;
        key_n = 4'b0111;
        repeat (4) tick();
        total++;
        if (dout !== 16'h0000) begin
            bad++;
            $display("FAIL mid_pre got=%h exp=0000", dout);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (dout !== 16'h0000) begin
            bad++;
            $display("FAIL mid_rst_addr1 got=%h exp=0000", dout);
        end
        addr = 1'b0;
        #1;
        total++;
        if (dout !== 16'h0000) begin
            bad++;
            $display("FAIL mid_rst_addr0 got=%h exp=0000", dout);
        end
        addr    = 1'b1;
        reset_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            exp = (e == 6) ? 16'h0088 : 16'h0000;
            total++;
            if (dout !== exp) begin
                bad++;
                $display("FAIL mid_after_edge%0d got=%h exp=%h", e, dout, exp);
            end
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        sw      = '0;
        key_n   = 4'hF;
        addr    = 1'b0;
        din     = '0;
        load    = 1'b0;
        test_reset();
        test_bounce();
        test_key_press();
        test_w1c();
        test_collision();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
